// File: rtl/conv_window_sequencer.sv
// Control sequencer for a multi-channel, stride-aware sliding-window convolution
// over a row shift buffer, with tree-latency-matched valid/done flags.
module conv_window_sequencer #(
    parameter int IMG_W         = 6,
    parameter int IMG_H         = 4,
    parameter int K_W           = 3,
    parameter int K_H           = 3,
    parameter int STRIDE        = 1,
    parameter int NUM_CH        = 2,
    parameter int MA_TREE_DEPTH = 4,
    parameter int CNT_BW        = 16,
    parameter int CH_BW         = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              busy,
    output logic              shift_en,
    output logic              shift_row_up,
    output logic              window_valid,
    output logic              out_valid,
    output logic [CH_BW-1:0]  channel_sel,
    output logic [CNT_BW-1:0] row_idx,
    output logic [CNT_BW-1:0] col_idx,
    output logic              conv_done
);

    localparam int ROW_MAX = IMG_H - K_H + 1;
    localparam int PH_BW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int DR_BW   = (MA_TREE_DEPTH > 1) ? $clog2(MA_TREE_DEPTH) : 1;

    localparam logic [CNT_BW-1:0] COL_LAST = CNT_BW'(IMG_W - 1);
    localparam logic [CNT_BW-1:0] COL_WIN  = CNT_BW'(K_W - 1);
    localparam logic [CNT_BW-1:0] ROW_LAST = CNT_BW'(ROW_MAX - 1);
    localparam logic [CH_BW-1:0]  CH_LAST  = CH_BW'(NUM_CH - 1);
    localparam logic [PH_BW-1:0]  PH_LAST  = PH_BW'(STRIDE - 1);
    localparam logic [DR_BW-1:0]  DR_LAST  = DR_BW'(MA_TREE_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [CNT_BW-1:0]        col, col_nxt;
    logic [CNT_BW-1:0]        row, row_nxt;
    logic [CH_BW-1:0]         ch, ch_nxt;
    logic [PH_BW-1:0]         col_ph, col_ph_nxt;
    logic [PH_BW-1:0]         row_ph, row_ph_nxt;
    logic [DR_BW-1:0]         drain_cnt, drain_nxt;
    logic                     done_pre;
    logic                     col_in_win;
    logic [MA_TREE_DEPTH-1:0] win_pipe;
    logic [MA_TREE_DEPTH-1:0] done_pipe;

    // Written as == / > so a K_W of 1 does not produce an always-true unsigned compare.
    assign col_in_win = (col == COL_WIN) || (col > COL_WIN);

    always_comb begin
        state_nxt    = state;
        col_nxt      = col;
        row_nxt      = row;
        ch_nxt       = ch;
        col_ph_nxt   = col_ph;
        row_ph_nxt   = row_ph;
        drain_nxt    = drain_cnt;
        shift_en     = 1'b0;
        shift_row_up = 1'b0;
        window_valid = 1'b0;
        done_pre     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = RUN;
                    col_nxt    = '0;
                    row_nxt    = '0;
                    ch_nxt     = '0;
                    col_ph_nxt = '0;
                    row_ph_nxt = '0;
                    drain_nxt  = '0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    shift_en     = 1'b1;
                    window_valid = col_in_win && (col_ph == '0) && (row_ph == '0);
                    if (col_in_win) begin
                        col_ph_nxt = (col_ph == PH_LAST) ? '0 : col_ph + 1'b1;
                    end
                    if (col == COL_LAST) begin
                        shift_row_up = 1'b1;
                        col_nxt      = '0;
                        col_ph_nxt   = '0;
                        row_ph_nxt   = (row_ph == PH_LAST) ? '0 : row_ph + 1'b1;
                        if (row == ROW_LAST) begin
                            row_nxt    = '0;
                            row_ph_nxt = '0;
                            if (ch == CH_LAST) begin
                                // Final advance of the frame: counters are already back at 0.
                                state_nxt = DRAIN;
                                ch_nxt    = '0;
                                done_pre  = 1'b1;
                            end else begin
                                ch_nxt = ch + 1'b1;
                            end
                        end else begin
                            row_nxt = row + 1'b1;
                        end
                    end else begin
                        col_nxt = col + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DR_LAST) begin
                    state_nxt = IDLE;
                    drain_nxt = '0;
                end else begin
                    drain_nxt = drain_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            ch        <= '0;
            col_ph    <= '0;
            row_ph    <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            ch        <= ch_nxt;
            col_ph    <= col_ph_nxt;
            row_ph    <= row_ph_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Tree-latency delay lines: free-running, they keep shifting through stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_pipe  <= '0;
            done_pipe <= '0;
        end else begin
            win_pipe[0]  <= window_valid;
            done_pipe[0] <= done_pre;
            for (int i = 1; i < MA_TREE_DEPTH; i++) begin
                win_pipe[i]  <= win_pipe[i-1];
                done_pipe[i] <= done_pipe[i-1];
            end
        end
    end

    assign busy        = (state != IDLE);
    assign out_valid   = win_pipe[MA_TREE_DEPTH-1];
    assign conv_done   = done_pipe[MA_TREE_DEPTH-1];
    assign channel_sel = ch;
    assign row_idx     = row;
    assign col_idx     = col;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: three differently-configured instances share
// one random stimulus stream and are scored against an arithmetic frame model.
module tb_conv_window_sequencer;

    localparam int N    = 3;
    localparam int HMAX = 4096;

    // Instance 0: defaults; 1: STRIDE=2; 2: 4x4 image, 1x4 kernel, one channel, short tree.
    localparam int CFG_IW  [N] = '{6, 6, 4};
    localparam int CFG_IH  [N] = '{4, 4, 4};
    localparam int CFG_KW  [N] = '{3, 3, 1};
    localparam int CFG_KH  [N] = '{3, 3, 4};
    localparam int CFG_ST  [N] = '{1, 2, 1};
    localparam int CFG_NCH [N] = '{2, 2, 1};
    localparam int CFG_MA  [N] = '{4, 4, 2};

    typedef struct packed {
        logic [5:0]  ctl;   // busy, shift_en, shift_row_up, window_valid, out_valid, conv_done
        logic [47:0] pos;   // channel, row, col
    } exp_t;

    logic        clock, reset, start, in_valid;
    logic        busy_w  [N];
    logic        shift_w [N];
    logic        rup_w   [N];
    logic        win_w   [N];
    logic        ov_w    [N];
    logic        done_w  [N];
    logic [0:0]  ch_w    [N];
    logic [15:0] row_w   [N];
    logic [15:0] col_w   [N];
    logic [5:0]  act_ctl [N];
    logic [47:0] act_pos [N];

    exp_t exp_q [N][$];
    exp_t mon_e;
    int   m_st [N];
    int   m_k  [N];
    int   m_dr [N];
    bit   hw   [N][HMAX];
    bit   hd   [N][HMAX];
    int   cyc;
    int   total;
    int   bad;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    conv_window_sequencer #(
        .IMG_W(CFG_IW[0]), .IMG_H(CFG_IH[0]), .K_W(CFG_KW[0]), .K_H(CFG_KH[0]),
        .STRIDE(CFG_ST[0]), .NUM_CH(CFG_NCH[0]), .MA_TREE_DEPTH(CFG_MA[0]),
        .CNT_BW(16), .CH_BW(1)
    ) dut0 (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .busy(busy_w[0]), .shift_en(shift_w[0]), .shift_row_up(rup_w[0]),
        .window_valid(win_w[0]), .out_valid(ov_w[0]), .channel_sel(ch_w[0]),
        .row_idx(row_w[0]), .col_idx(col_w[0]), .conv_done(done_w[0])
    );

    conv_window_sequencer #(
        .IMG_W(CFG_IW[1]), .IMG_H(CFG_IH[1]), .K_W(CFG_KW[1]), .K_H(CFG_KH[1]),
        .STRIDE(CFG_ST[1]), .NUM_CH(CFG_NCH[1]), .MA_TREE_DEPTH(CFG_MA[1]),
        .CNT_BW(16), .CH_BW(1)
    ) dut1 (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .busy(busy_w[1]), .shift_en(shift_w[1]), .shift_row_up(rup_w[1]),
        .window_valid(win_w[1]), .out_valid(ov_w[1]), .channel_sel(ch_w[1]),
        .row_idx(row_w[1]), .col_idx(col_w[1]), .conv_done(done_w[1])
    );

    conv_window_sequencer #(
        .IMG_W(CFG_IW[2]), .IMG_H(CFG_IH[2]), .K_W(CFG_KW[2]), .K_H(CFG_KH[2]),
        .STRIDE(CFG_ST[2]), .NUM_CH(CFG_NCH[2]), .MA_TREE_DEPTH(CFG_MA[2]),
        .CNT_BW(16), .CH_BW(1)
    ) dut2 (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .busy(busy_w[2]), .shift_en(shift_w[2]), .shift_row_up(rup_w[2]),
        .window_valid(win_w[2]), .out_valid(ov_w[2]), .channel_sel(ch_w[2]),
        .row_idx(row_w[2]), .col_idx(col_w[2]), .conv_done(done_w[2])
    );

    always_comb begin
        for (int i = 0; i < N; i++) begin
            act_ctl[i] = {busy_w[i], shift_w[i], rup_w[i], win_w[i], ov_w[i], done_w[i]};
            act_pos[i] = {15'b0, ch_w[i], row_w[i], col_w[i]};
        end
    end

    // Reference: a frame is the ordered list of advances k = 0..len-1; position,
    // window and done flags follow from k by division and modulo.
    task automatic model_step(input int i, input bit st, input bit iv, input bit rst);
        exp_t e;
        int   rm, len, ch, row, col;
        bit   bz, adv, rup, win, dpre, ov, dn;
        e   = '0;
        rm  = CFG_IH[i] - CFG_KH[i] + 1;
        len = CFG_IW[i] * rm * CFG_NCH[i];
        if (rst) begin
            m_st[i] = 0;
            m_k[i]  = 0;
            m_dr[i] = 0;
            for (int c = 0; c < HMAX; c++) begin
                hw[i][c] = 1'b0;
                hd[i][c] = 1'b0;
            end
            exp_q[i].push_back(e);
            return;
        end
        bz  = (m_st[i] != 0);
        adv = (m_st[i] == 1) && iv;
        ch  = 0;
        row = 0;
        col = 0;
        if (m_st[i] == 1) begin
            ch  = m_k[i] / (CFG_IW[i] * rm);
            row = (m_k[i] / CFG_IW[i]) % rm;
            col = m_k[i] % CFG_IW[i];
        end
        rup  = adv && (col == CFG_IW[i] - 1);
        win  = adv && (col >= CFG_KW[i] - 1) && (((col - CFG_KW[i] + 1) % CFG_ST[i]) == 0)
               && ((row % CFG_ST[i]) == 0);
        dpre = adv && (m_k[i] == len - 1);
        if (cyc < HMAX) begin
            hw[i][cyc] = win;
            hd[i][cyc] = dpre;
        end
        ov = (cyc >= CFG_MA[i] && cyc - CFG_MA[i] < HMAX) ? hw[i][cyc - CFG_MA[i]] : 1'b0;
        dn = (cyc >= CFG_MA[i] && cyc - CFG_MA[i] < HMAX) ? hd[i][cyc - CFG_MA[i]] : 1'b0;
        e.ctl = {bz, adv, rup, win, ov, dn};
        e.pos = {16'(ch), 16'(row), 16'(col)};
        exp_q[i].push_back(e);
        if (m_st[i] == 0) begin
            if (st) begin
                m_st[i] = 1;
                m_k[i]  = 0;
            end
        end else if (m_st[i] == 1) begin
            if (dpre) begin
                m_st[i] = 2;
                m_dr[i] = CFG_MA[i];
            end else if (adv) begin
                m_k[i] = m_k[i] + 1;
            end
        end else begin
            m_dr[i] = m_dr[i] - 1;
            if (m_dr[i] == 0) m_st[i] = 0;
        end
    endtask

    task automatic step(input bit st, input bit iv, input bit rst);
        @(posedge clock);
        #1;
        start    = st;
        in_valid = iv;
        if (rst) begin
            #1;
            reset = 1'b0;
        end else begin
            reset = 1'b1;
        end
        for (int i = 0; i < N; i++) model_step(i, st, iv, rst);
        cyc = cyc + 1;
    endtask

    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (exp_q[i].size() > 0) begin
                mon_e = exp_q[i].pop_front();
                total = total + 1;
                if (act_ctl[i] !== mon_e.ctl) begin
                    bad = bad + 1;
                    $display("FAIL ctl dut%0d t=%0t got=%b want=%b (busy,shift,rowup,win,ov,done)",
                             i, $time, act_ctl[i], mon_e.ctl);
                end
                total = total + 1;
                if (act_pos[i] !== mon_e.pos) begin
                    bad = bad + 1;
                    $display("FAIL pos dut%0d t=%0t got ch/row/col=%0d/%0d/%0d want=%0d/%0d/%0d",
                             i, $time, act_pos[i][47:32], act_pos[i][31:16], act_pos[i][15:0],
                             mon_e.pos[47:32], mon_e.pos[31:16], mon_e.pos[15:0]);
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        cyc      = 0;
        total    = 0;
        bad      = 0;
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0;
            m_k[i]  = 0;
            m_dr[i] = 0;
        end
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Full frame with no stalls.
        step(1'b1, 1'b1, 1'b0);
        repeat (34) step(1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Full frame with in_valid alternating.
        step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 60; j++) step(1'b0, (j % 2) == 0, 1'b0);

        // Random stalls with stray start pulses in every state.
        for (int j = 0; j < 400; j++)
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 1'b0);

        // start held high: each frame restarts on the cycle busy falls.
        repeat (80) step(1'b1, 1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b1, 1'b0);

        // Abort with reset on the 10th advance of a frame.
        step(1'b1, 1'b1, 1'b0);
        repeat (9) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 20; j++) step(1'b0, $urandom_range(0, 1) == 1, 1'b0);

        // One more frame after the abort, random stalls.
        step(1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 150; j++) step(1'b0, $urandom_range(0, 1) == 1, 1'b0);

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Parametrised successor to the single-channel convolution control FSM.
- Sequences a multi-channel, stride-aware sliding-window convolution over a row shift-register buffer.
- Drives shift and row-advance strobes, flags which shift positions form valid output windows, and delays the valid and done flags by the multiply-add tree latency.
- Adds a start/busy handshake, input stall support and a drain phase.

Parameters:
- IMG_W, 6: columns per buffer row (shifts per row).
- IMG_H, 4: rows held in the row shift buffer.
- K_W, 3: kernel width.
- K_H, 3: kernel height. Non-square kernels are allowed; K_H <= IMG_H and K_W <= IMG_W.
- STRIDE, 1: window stride in both dimensions, >= 1.
- NUM_CH, 2: input channels processed back-to-back per frame.
- MA_TREE_DEPTH, 4: multiply-add tree pipeline latency in cycles, >= 1.
- CNT_BW, 16: width of the row and column counters.
- CH_BW, 1: channel select width. Must satisfy 2^CH_BW >= NUM_CH.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  frame start pulse; sampled only in IDLE
- in_valid  in  1  input data available this cycle; low = stall
- busy  out  1  high from the cycle after an accepted start until drain completes
- shift_en  out  1  advance the buffer by one column this cycle
- shift_row_up  out  1  last column of the current row; buffer shifts up one row
- window_valid  out  1  current position is a valid output window (pre-tree)
- out_valid  out  1  window_valid delayed MA_TREE_DEPTH cycles
- channel_sel  out  CH_BW  channel currently being sequenced
- row_idx  out  CNT_BW  current row counter
- col_idx  out  CNT_BW  current column counter
- conv_done  out  1  one-cycle pulse, MA_TREE_DEPTH cycles after the final advance of the frame

Behaviour:
- Reset: asynchronous, active-low. Forces state=IDLE. Clears all counters, both delay shift registers and all outputs. Reset mid-frame aborts immediately; no conv_done is produced.
- States:
  - IDLE: start=1 -> RUN, with all counters cleared.
  - RUN: operates as described below.
  - DRAIN: counts MA_TREE_DEPTH cycles, then -> IDLE.
- advance = (state==RUN) & in_valid.
- shift_en = advance. It is combinational from state and in_valid.
- With in_valid=0, all counters hold and shift_en, shift_row_up and window_valid are 0.
- ROW_MAX = IMG_H-K_H+1.
- On each advance:
  - col increments.
  - At col==IMG_W-1: shift_row_up=1 and col wraps to 0.
  - The row then increments. At row==ROW_MAX-1 it wraps to 0 and channel_sel increments.
- Final advance: col==IMG_W-1, row==ROW_MAX-1, channel_sel==NUM_CH-1. State -> DRAIN, counters return to 0, and conv_done_pre=1 on that cycle.
- Stride phases: col_phase and row_phase counters run 0..STRIDE-1.
  - col_phase starts counting when col reaches K_W-1 and resets at each row wrap.
  - row_phase increments on each row wrap and resets on channel wrap.
  - No divider or modulo hardware.
- window_valid = advance & (col >= K_W-1) & (col_phase==0) & (row_phase==0).
- Delay lines: out_valid and conv_done come from MA_TREE_DEPTH-stage shift registers.
  - They shift every cycle, free-running and independent of stall.
  - Latency from window_valid to out_valid is exactly MA_TREE_DEPTH cycles.
- busy = (state != IDLE).
- start is ignored in RUN and DRAIN.
- conv_done coincides with the last DRAIN cycle. busy falls on the following cycle, when state reaches IDLE.
- start at the same cycle busy falls is accepted; back-to-back frames are permitted.
- row_idx, col_idx and channel_sel are registered and reflect the pre-advance position.

Test Plan:
- Defaults, start pulse, in_valid held 1:
  - 24 shift_en cycles, 4 shift_row_up pulses, 16 window_valid pulses.
  - conv_done exactly 4 cycles after the 24th shift_en; busy low on the next cycle.
- Defaults, in_valid toggled 1,0,1,0... for the full frame:
  - Same counts as the previous scenario (24/4/16); no counter changes on stall cycles.
  - out_valid pulses are each 4 cycles after their window_valid.
- STRIDE=2, defaults otherwise:
  - window_valid only at col 2 and 4 of row 0 of each channel: 4 total.
  - The 4th window_valid is followed by 1 conv_done at the frame end.
- start asserted mid-RUN and again during DRAIN:
  - Counters unaffected, no restart.
  - start on the cycle busy falls begins a new frame with col=row=ch=0.
- reset driven low at advance 10 (channel 0, row 1, col 3):
  - Within that cycle, all outputs are 0 and state=IDLE.
  - No conv_done and no out_valid appear afterwards.
- K_W=1, K_H=IMG_H=4, IMG_W=4, NUM_CH=1:
  - ROW_MAX=1, window_valid on all 4 advances, 1 shift_row_up.
  - conv_done MA_TREE_DEPTH cycles after the 4th advance.
